// File: rtl/rr_arbiter8_pkg.sv
// rtl/rr_arbiter8_pkg.sv - shared widths, state encoding and helpers for the 8-way arbiter
package rr_arbiter8_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  function automatic logic [N_REQ-1:0] id2onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] one;
    one = {{(N_REQ-1){1'b0}}, 1'b1};
    return one << id;
  endfunction

  function automatic logic [ID_W:0] id2num(input logic [ID_W-1:0] id);
    return {1'b0, id} + {{ID_W{1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin winner select: rotate requests by ptr, then priority-encode
module rr_pick
  import rr_arbiter8_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             found,
  output logic [ID_W-1:0]  id
);

  logic [N_REQ-1:0] rot;
  logic [ID_W-1:0]  off;

  // rot[0] is the requester at ptr, rot[7] the one just before it
  always_comb begin
    rot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[ID_W'(i) + ptr];
    end
  end

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = ID_W'(i);
      end
    end
  end

  assign id = off + ptr;

endmodule

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-way round-robin arbiter with hold limit and one-cycle turnaround gap
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [ID_W-1:0]  gnt_id,
  output logic [ID_W:0]    gnt_num,
  output logic             preempt
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ID_W-1:0]  ID_ONE   = {{(ID_W-1){1'b0}}, 1'b1};

  arb_state_t       state;
  logic [ID_W-1:0]  ptr;
  logic [CNT_W-1:0] cnt;
  logic             pick_found;
  logic [ID_W-1:0]  pick_id;

  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .id    (pick_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      gnt_num   <= '0;
      preempt   <= 1'b0;
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (pick_found) begin
            state     <= GRANT;
            cnt       <= CNT_ONE;
            gnt       <= id2onehot(pick_id);
            gnt_valid <= 1'b1;
            gnt_id    <= pick_id;
            gnt_num   <= id2num(pick_id);
          end else begin
            state     <= IDLE;
            cnt       <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            gnt_num   <= '0;
          end
        end
        GRANT: begin
          // a voluntary drop wins over the hold limit when both land on the same edge
          if (!req[gnt_id] || (MAX_HOLD != 0 && cnt == HOLD_LIM)) begin
            state     <= GAP;
            ptr       <= gnt_id + ID_ONE;
            preempt   <= req[gnt_id];
            cnt       <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            gnt_num   <= '0;
          end else if (cnt != CNT_SAT) begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          gnt       <= '0;
          gnt_valid <= 1'b0;
          gnt_id    <= '0;
          gnt_num   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - scoreboard bench for rr_arbiter8 at hold limits 4, 16 and unlimited
module tb_rr_arbiter8;

  typedef struct {
    int         cyc;
    int         d;
    string      tag;
    logic [7:0] gnt;
    logic       v;
    logic [2:0] id;
    logic [3:0] num;
    logic       pre;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_a [3];
  logic [7:0] gnt_a [3];
  logic       gv_a  [3];
  logic [2:0] id_a  [3];
  logic [3:0] num_a [3];
  logic       pre_a [3];

  exp_t  q[$];
  int    cyc = 0;
  int    n_vec = 0;
  int    n_bad = 0;
  string tname = "init";

  rr_arbiter8 #(.MAX_HOLD(4)) u_h4 (
    .clk(clk), .rst_n(rst_n), .req(req_a[0]), .gnt(gnt_a[0]), .gnt_valid(gv_a[0]),
    .gnt_id(id_a[0]), .gnt_num(num_a[0]), .preempt(pre_a[0]));
  rr_arbiter8 u_h16 (
    .clk(clk), .rst_n(rst_n), .req(req_a[1]), .gnt(gnt_a[1]), .gnt_valid(gv_a[1]),
    .gnt_id(id_a[1]), .gnt_num(num_a[1]), .preempt(pre_a[1]));
  rr_arbiter8 #(.MAX_HOLD(0)) u_h0 (
    .clk(clk), .rst_n(rst_n), .req(req_a[2]), .gnt(gnt_a[2]), .gnt_valid(gv_a[2]),
    .gnt_id(id_a[2]), .gnt_num(num_a[2]), .preempt(pre_a[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input int c, input int d, input bit v, input logic [2:0] id, input bit pre);
    exp_t e;
    e.cyc = c;
    e.d   = d;
    e.tag = tname;
    e.v   = v;
    e.gnt = v ? (8'd1 << id) : 8'd0;
    e.id  = v ? id : 3'd0;
    e.num = v ? ({1'b0, id} + 4'd1) : 4'd0;
    e.pre = pre;
    return e;
  endfunction

  task automatic check(input exp_t e);
    logic [16:0] act, want;
    act  = {gnt_a[e.d], gv_a[e.d], id_a[e.d], num_a[e.d], pre_a[e.d]};
    want = {e.gnt, e.v, e.id, e.num, e.pre};
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s dut%0d cyc%0d: got gnt=%h v=%b id=%0d num=%0d pre=%b, want gnt=%h v=%b id=%0d num=%0d pre=%b",
               e.tag, e.d, e.cyc, gnt_a[e.d], gv_a[e.d], id_a[e.d], num_a[e.d], pre_a[e.d],
               e.gnt, e.v, e.id, e.num, e.pre);
    end
  endtask

  // monitor: compares every expectation that falls due at this edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.cyc < cyc) begin
          n_vec++;
          n_bad++;
          $display("FAIL %s stale expectation: due cyc%0d, now cyc%0d", e.tag, e.cyc, cyc);
        end else begin
          check(e);
        end
      end
    end
  end

  // called half-way between edges; leaves the phase unchanged
  task automatic step(input int d, input logic [7:0] r, input bit v, input logic [2:0] id, input bit pre);
    req_a[d] = r;
    q.push_back(mk(cyc + 1, d, v, id, pre));
    @(posedge clk);
    #2;
  endtask

  // asynchronous reset: outputs must clear before any clock edge
  task automatic do_reset();
    for (int i = 0; i < 3; i++) req_a[i] = 8'h00;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) check(mk(cyc, i, 1'b0, 3'd0, 1'b0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) req_a[i] = 8'h00;
    @(posedge clk);
    #2;
    tname = "reset";
    do_reset();

    tname = "single";
    step(1, 8'h04, 1, 3'd2, 0);
    step(1, 8'h04, 1, 3'd2, 0);
    step(1, 8'h00, 0, 3'd0, 0);
    step(1, 8'hFF, 1, 3'd3, 0);
    step(1, 8'h00, 0, 3'd0, 0);
    step(1, 8'h00, 0, 3'd0, 0);

    tname = "rotate_h4";
    do_reset();
    for (int o = 0; o < 9; o++) begin
      for (int k = 0; k < 4; k++) step(0, 8'hFF, 1, 3'(o % 8), 0);
      step(0, 8'hFF, 0, 3'd0, 1);
    end
    step(0, 8'h00, 0, 3'd0, 0);

    tname = "turn_h4";
    do_reset();
    for (int k = 0; k < 4; k++) step(0, 8'h03, 1, 3'd0, 0);
    step(0, 8'h03, 0, 3'd0, 1);
    for (int k = 0; k < 4; k++) step(0, 8'h03, 1, 3'd1, 0);
    step(0, 8'h03, 0, 3'd0, 1);
    step(0, 8'h03, 1, 3'd0, 0);
    step(0, 8'h00, 0, 3'd0, 0);
    step(0, 8'h00, 0, 3'd0, 0);

    tname = "drop_at_limit";
    do_reset();
    for (int k = 0; k < 16; k++) step(1, 8'h20, 1, 3'd5, 0);
    step(1, 8'h00, 0, 3'd0, 0);
    step(1, 8'hFF, 1, 3'd6, 0);
    tname = "preempt_h16";
    for (int k = 0; k < 15; k++) step(1, 8'h40, 1, 3'd6, 0);
    step(1, 8'h40, 0, 3'd0, 1);
    step(1, 8'h40, 1, 3'd6, 0);
    step(1, 8'h00, 0, 3'd0, 0);
    step(1, 8'h00, 0, 3'd0, 0);

    tname = "ignore_others";
    do_reset();
    step(1, 8'h02, 1, 3'd1, 0);
    for (int k = 0; k < 3; k++) step(1, 8'h42, 1, 3'd1, 0);
    step(1, 8'h40, 0, 3'd0, 0);
    step(1, 8'h40, 1, 3'd6, 0);
    step(1, 8'h00, 0, 3'd0, 0);
    step(1, 8'h00, 0, 3'd0, 0);

    tname = "reset_mid";
    do_reset();
    for (int k = 0; k < 3; k++) step(1, 8'h08, 1, 3'd3, 0);
    do_reset();
    step(1, 8'h80, 1, 3'd7, 0);
    step(1, 8'h00, 0, 3'd0, 0);
    step(1, 8'h00, 0, 3'd0, 0);

    tname = "unlimited";
    do_reset();
    for (int k = 0; k < 100; k++) step(2, 8'h08, 1, 3'd3, 0);
    step(2, 8'h00, 0, 3'd0, 0);
    step(2, 8'h00, 0, 3'd0, 0);

    @(posedge clk);
    #3;
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
